// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the tinyGPU ALU: default datapath width, the opcode
// type and the opcode encodings. Imported by alu_comb and alu.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Default operand/result width. The opcode map and the 4-bit shift
    // amount (B[3:0]) assume 16 bits.
    localparam int ALU_WIDTH = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_CLR = 4'd0;
    localparam opcode_t OP_ADD = 4'd1;
    localparam opcode_t OP_SUB = 4'd2;
    localparam opcode_t OP_MUL = 4'd3;
    localparam opcode_t OP_MAD = 4'd4;
    localparam opcode_t OP_AND = 4'd5;
    localparam opcode_t OP_OR  = 4'd6;
    localparam opcode_t OP_XOR = 4'd7;
    localparam opcode_t OP_SHL = 4'd8;
    localparam opcode_t OP_SLT = 4'd9;
    // Encodings 10..15 are reserved and decode exactly like OP_CLR.

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational opcode decode and datapath. Produces the value the
// top level will register as the result and the predicate flag.
//
// Ports:
//   a, b, c      operands (b also supplies the shift amount in b[3:0],
//                c is the addend for MAD)
//   opcode       4-bit operation select
//   result_next  next result (unsigned, modulo 2^WIDTH)
//   p_next       next predicate: zero flag for ADD..SHL, A<B for SLT,
//                0 for CLR and reserved encodings
// -----------------------------------------------------------------------------
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  opcode_t          opcode,
    output logic [WIDTH-1:0] result_next,
    output logic             p_next
);

    logic a_lt_b;
    logic uses_zero_flag;

    assign a_lt_b         = (a < b);
    assign uses_zero_flag = (opcode >= OP_ADD) && (opcode <= OP_SHL);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; otherwise a latch would be inferred.
        result_next = '0;
        p_next      = 1'b0;

        case (opcode)
            OP_ADD: result_next = a + b;
            OP_SUB: result_next = a - b;
            // Products are truncated to WIDTH bits by the assignment context.
            OP_MUL: result_next = a * b;
            OP_MAD: result_next = a * b + c;
            OP_AND: result_next = a & b;
            OP_OR:  result_next = a | b;
            OP_XOR: result_next = a ^ b;
            // Only the low four bits of b form the shift amount.
            OP_SHL: result_next = a << b[3:0];
            OP_SLT: begin
                result_next = {{(WIDTH-1){1'b0}}, a_lt_b};
                p_next      = a_lt_b;
            end
            default: ; // CLR and reserved opcodes keep the zero defaults
        endcase

        if (uses_zero_flag) begin
            p_next = (result_next == '0);
        end
    end

endmodule : alu_comb

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// 16-bit three-operand ALU for the tinyGPU datapath. One register stage:
// inputs sampled on a rising clock edge appear on ALU_OUT/P one cycle later.
// A new operation is accepted every cycle; there is no handshake.
//
// Ports:
//   clock    system clock, rising edge active
//   reset_n  asynchronous active-low reset; clears ALU_OUT and P
//   A, B, C  operands (B[3:0] is the shift amount, C the MAD addend)
//   ALU_C    4-bit opcode
//   ALU_OUT  registered result
//   P        registered predicate flag
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  opcode_t          ALU_C,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             P
);

    logic [WIDTH-1:0] result_next;
    logic             p_next;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .a           (A),
        .b           (B),
        .c           (C),
        .opcode      (ALU_C),
        .result_next (result_next),
        .p_next      (p_next)
    );

    // Reset clears the outputs immediately, discarding any in-flight result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ALU_OUT <= '0;
            P       <= 1'b0;
        end else begin
            // NOTE: registers are written with non-blocking assignments so all
            // flops update together from pre-edge values.
            ALU_OUT <= result_next;
            P       <= p_next;
        end
    end

endmodule : alu

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu. The stimulus process drives one operation per
// cycle on the falling edge and pushes the hand-computed expected response
// into a scoreboard queue; an independent monitor samples the outputs just
// after each rising edge and compares them with the oldest queued entry.
// Reset behaviour is checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    opcode_t      ALU_C;
    logic [W-1:0] ALU_OUT;
    logic         P;

    alu #(
        .WIDTH (W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .C       (C),
        .ALU_C   (ALU_C),
        .ALU_OUT (ALU_OUT),
        .P       (P)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [W-1:0] result;
        logic         p;
    } expect_t;

    expect_t sb[$];

    int n_total  = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_total++;
        if (actual === expected) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one operation on the falling edge and queue its expected outcome.
    task automatic issue(input string name, input opcode_t op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c,
                         input logic [W-1:0] exp_result, input logic exp_p);
        expect_t e;
        @(negedge clock);
        A     = a;
        B     = b;
        C     = c;
        ALU_C = op;
        e.name   = name;
        e.result = exp_result;
        e.p      = exp_p;
        sb.push_back(e);
    endtask

    // Monitor: every rising edge registers a new result, so an entry issued
    // before the edge must be visible right after it.
    initial begin
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.name, " ALU_OUT"}, 32'(ALU_OUT), 32'(e.result));
                check({e.name, " P"}, 32'(P), 32'(e.p));
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        expect_t e0;
        int      waited;

        // ---------------- Reset held with live inputs ----------------
        reset_n = 1'b0;
        A       = 16'd25;
        B       = 16'd2;
        C       = 16'd5;
        ALU_C   = OP_ADD;
        #1;
        check("reset t0 ALU_OUT", 32'(ALU_OUT), 32'h0);
        check("reset t0 P", 32'(P), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("reset hold %0d ALU_OUT", i), 32'(ALU_OUT), 32'h0);
            check($sformatf("reset hold %0d P", i), 32'(P), 32'h0);
        end

        // Release on a falling edge; ADD 25+2 is captured on the next rise.
        @(negedge clock);
        reset_n = 1'b1;
        e0.name = "first capture ADD";
        e0.result = 16'd27;
        e0.p = 1'b0;
        sb.push_back(e0);

        // ---------------- Arithmetic sweep ----------------
        issue("CLR",  OP_CLR, 16'd25, 16'd2, 16'd5, 16'd0,  1'b0);
        issue("ADD",  OP_ADD, 16'd25, 16'd2, 16'd5, 16'd27, 1'b0);
        issue("SUB",  OP_SUB, 16'd25, 16'd2, 16'd5, 16'd23, 1'b0);
        issue("MUL",  OP_MUL, 16'd25, 16'd2, 16'd5, 16'd50, 1'b0);
        issue("MAD",  OP_MAD, 16'd25, 16'd2, 16'd5, 16'd55, 1'b0);

        // ---------------- Logic / shift sweep ----------------
        issue("AND",        OP_AND, 16'd25, 16'd2,      16'd5, 16'd0,   1'b1);
        issue("OR",         OP_OR,  16'd25, 16'd2,      16'd5, 16'd27,  1'b0);
        issue("XOR",        OP_XOR, 16'd25, 16'd2,      16'd5, 16'd27,  1'b0);
        issue("XOR self",   OP_XOR, 16'h1234, 16'h1234, 16'd0, 16'd0,   1'b1);
        issue("SHL",        OP_SHL, 16'd25, 16'd2,      16'd5, 16'd100, 1'b0);
        issue("SHL B=0x12", OP_SHL, 16'd25, 16'h0012,   16'd5, 16'd100, 1'b0);
        issue("SHL by 15",  OP_SHL, 16'h8001, 16'd15,   16'd0, 16'h8000, 1'b0);
        issue("SHL to 0",   OP_SHL, 16'h0002, 16'd15,   16'd0, 16'h0000, 1'b1);

        // ---------------- Compare ----------------
        issue("SLT 25<2",  OP_SLT, 16'd25, 16'd2,  16'd0, 16'd0, 1'b0);
        issue("SLT 2<25",  OP_SLT, 16'd2,  16'd25, 16'd0, 16'd1, 1'b1);
        issue("SLT 7<7",   OP_SLT, 16'd7,  16'd7,  16'd0, 16'd0, 1'b0);
        issue("SLT big",   OP_SLT, 16'h7FFF, 16'h8000, 16'd0, 16'd1, 1'b1);

        // ---------------- Wrap-around ----------------
        issue("SUB wrap",  OP_SUB, 16'd2,     16'd25,    16'd0, 16'hFFE9, 1'b0);
        issue("ADD wrap",  OP_ADD, 16'hFFFF,  16'd1,     16'd0, 16'h0000, 1'b1);
        issue("MUL wrap",  OP_MUL, 16'h0100,  16'h0100,  16'd0, 16'h0000, 1'b1);
        issue("MAD wrap",  OP_MAD, 16'hFFFF,  16'd1,     16'd1, 16'h0000, 1'b1);

        // ---------------- Reserved opcodes ----------------
        for (int op = 10; op < 16; op++) begin
            issue($sformatf("reserved %0d", op), opcode_t'(op),
                  16'd25, 16'd2, 16'd5, 16'd0, 1'b0);
        end

        // ---------------- Back-to-back ----------------
        issue("b2b ADD", OP_ADD, 16'd100,  16'd200, 16'd0, 16'd300,   1'b0);
        issue("b2b SUB", OP_SUB, 16'd1000, 16'd1,   16'd0, 16'd999,   1'b0);
        issue("b2b MUL", OP_MUL, 16'd300,  16'd300, 16'd0, 16'h5F90,  1'b0);
        issue("b2b MAD", OP_MAD, 16'd3,    16'd4,   16'd5, 16'd17,    1'b0);

        // ---------------- Asynchronous reset mid-cycle ----------------
        issue("pre-reset ADD", OP_ADD, 16'd25, 16'd2, 16'd5, 16'd27, 1'b0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset ALU_OUT", 32'(ALU_OUT), 32'h0);
        check("async reset P", 32'(P), 32'h0);
        // Inputs still present an operation with a nonzero result and P=1.
        A     = 16'd7;
        B     = 16'd7;
        ALU_C = OP_SUB;
        @(posedge clock);
        #1;
        check("reset across edge ALU_OUT", 32'(ALU_OUT), 32'h0);
        check("reset across edge P", 32'(P), 32'h0);

        @(negedge clock);
        reset_n = 1'b1;
        issue("post-reset OR", OP_OR, 16'hF000, 16'h000F, 16'd0, 16'hF00F, 1'b0);
        issue("post-reset SUB0", OP_SUB, 16'd7, 16'd7, 16'd0, 16'd0, 1'b1);

        // Drain the scoreboard within a bounded number of cycles.
        waited = 0;
        while (sb.size() != 0 && waited < 5) begin
            @(posedge clock);
            #2;
            waited++;
        end
        check("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule : tb_alu

// File: doc/alu.md
Name: alu

Overview:
- 16-bit, three-operand arithmetic/logic unit for the tinyGPU datapath.
- Takes operands A, B and C plus a 4-bit opcode, and produces a 16-bit result and a 1-bit predicate flag P.
- Both outputs are registered: a single pipeline stage sits between the register-read stage and writeback.

Parameters:
- WIDTH, 16, operand and result width. Opcode encoding assumes WIDTH=16; shift amount uses B[3:0].

Ports:
- clock  input  1  system clock; rising edge active.
- reset_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; also the shift amount.
- C  input  WIDTH  operand C; the addend for MAD.
- ALU_C  input  4  opcode.
- ALU_OUT  output  WIDTH  registered result.
- P  output  1  registered predicate/flag.

Behaviour:
- Reset:
  - reset_n low asynchronously forces ALU_OUT=0 and P=0, independent of clock.
  - Both outputs stay 0 while reset_n is low.
  - First capture happens on the first rising clock edge after deassertion.
- Latency:
  - Inputs are sampled on each rising clock edge.
  - ALU_OUT and P reflect that sample one cycle later.
  - No handshake; a new operation is accepted every cycle.
- Reset asserted mid-operation discards the in-flight result.
- All arithmetic is unsigned modulo 2^16; carries and overflow are discarded.
- Opcodes:
  - 0 CLR: result 0, P=0.
  - 1 ADD: A+B.
  - 2 SUB: A-B (wraps, e.g. 2-25 = 0xFFE9).
  - 3 MUL: low 16 bits of A*B.
  - 4 MAD: low 16 bits of A*B+C.
  - 5 AND: A&B.
  - 6 OR: A|B.
  - 7 XOR: A^B.
  - 8 SHL: A << B[3:0]; upper bits of B are ignored; zero fill.
  - 9 SLT: P=(A<B unsigned); result = {15'b0, P}.
  - 10-15 reserved: behave exactly as CLR (result 0, P=0).
- P for opcodes 1-8 is the zero flag: P=1 iff the 16-bit result is 0x0000.
- Combinational next-state has no dependence on the current outputs; there is no FSM.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams OP_CLR=0 … OP_SLT=9;
  - a WIDTH default constant;
  - an opcode typedef (logic [3:0]).
- Sub-module alu_comb: purely combinational opcode decode and datapath producing next result and next P.
- The top level alu registers the alu_comb outputs with the async active-low reset.

Test Plan:
- Reset: hold reset_n=0 with A=25, B=2, C=5, ALU_C=1 and clock toggling -> ALU_OUT=0, P=0 throughout. Assert reset_n=0 asynchronously mid-cycle -> outputs go to 0 immediately.
- Arithmetic sweep with A=25, B=2, C=5, one cycle per opcode, checking one cycle later:
  - CLR -> 0, P=0
  - ADD -> 27, P=0
  - SUB -> 23
  - MUL -> 50
  - MAD -> 55
- Logic/shift sweep with A=25, B=2:
  - AND -> 0, P=1
  - OR -> 27
  - XOR -> 27
  - SHL -> 100
  - SHL with B=0x0012 -> 100 (only B[3:0] used)
- Compare:
  - SLT with A=25, B=2 -> ALU_OUT=0, P=0.
  - SLT with A=2, B=25 -> ALU_OUT=1, P=1.
  - SLT with A=B=7 -> P=0.
- Wrap-around:
  - SUB with A=2, B=25 -> 0xFFE9, P=0.
  - ADD with 0xFFFF+1 -> 0, P=1.
  - MUL with 0x0100*0x0100 -> 0, P=1.
  - MAD with 0xFFFF*1+1 -> 0, P=1.
- Reserved and back-to-back: opcodes 10-15 -> 0, P=0. Opcode changes every cycle ADD, SUB, MUL -> each result appears exactly one cycle after its input, with no bubbles.
